iq_sample_tx: RTL and testbench
===============================

# iq_sample_tx

Transmit-side sample source for the dual-channel 4-bit I/Q pin interface. It buffers complex sample pairs pushed by an upstream producer and drives them onto two 8-bit buses with the pin packing the SDR datapath consumes: bus A = {Q1,I1}, bus B = {I2,Q2}. Each sample is held for a programmable number of cycles. The block sits at the far end of the pin interface: as a stimulus/loopback source on chip, or as the driver for an external DUT.

## Interface
- DEPTH, 4: FIFO depth in sample words; power of two, ≥2.
- HOLD_W, 4: width of the hold-count input.
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  global enable; 0 freezes all state.
- s_data  in  16  sample word: [3:0]=I1, [7:4]=Q1, [11:8]=Q2, [15:12]=I2.
- s_valid  in  1  producer has a word on s_data.
- s_ready  out  1  block accepts the word; push = s_valid & s_ready.
- hold  in  HOLD_W  each sample is driven for hold+1 cycles; sampled when a sample is loaded.
- clr_underrun  in  1  clears the underrun flag.
- out_a  out  8  {Q1,I1} of the current sample (s_data[7:0]).
- out_b  out  8  {I2,Q2} of the current sample (s_data[15:8]).
- out_valid  out  1  out_a/out_b carry a live sample.
- underrun  out  1  sticky: the stream ran dry after at least one sample.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- FIFO: circular buffer with DEPTH entries, read/write pointers and an occupancy counter.
  - s_ready = ena & (level < DEPTH). It is 0 when full even if a pop happens in the same cycle; there is no pass-through.
  - A push and a pop in the same cycle leave level unchanged. Pointers wrap modulo DEPTH.
- FSM, two states:
  - IDLE: out_valid=0, out_a=out_b=0. If level>0, pop the head word into the output registers, load hc←hold, and go to SEND.
  - SEND: out_valid=1, outputs hold the loaded word.
    - hc≠0: decrement hc.
    - hc=0 and level>0: pop the next word, reload hc←hold (current hold value), stay in SEND. This gives back-to-back output with no gap.
    - hc=0 and level=0: go to IDLE. Outputs clear to 0 and underrun is set.
- underrun: set on every SEND→IDLE transition. Cleared by clr_underrun or reset. If clr_underrun and the set condition occur in the same cycle, set wins.
- ena=0: FSM, hc, FIFO pointers and outputs all hold their values. s_ready=0, so no push occurs.
- Reset (rst_n=0 at a clock edge):
  - Block state: FIFO empty, level=0, FSM=IDLE, hc=0.
  - Outputs: out_a=0, out_b=0, out_valid=0, underrun=0.
  - s_ready: forced to 0 while rst_n=0.
  - Reset mid-SEND discards the buffered words and the current sample.

## Timing
- Outputs out_a, out_b, out_valid, underrun and level are registered. s_ready is combinational from level and ena.
- Latency: a word pushed at edge N into an empty FIFO while in IDLE is popped at edge N+1. It is visible on out_a/out_b with out_valid=1 in the cycle after edge N+1 (two edges after the push).
- Each sample is visible for exactly hold+1 cycles while ena=1. A hold change takes effect at the next load only.
- Continuous stream: with hold=0 and level never zero at a pop edge, out_valid stays 1 and a new sample appears every cycle. Throughput is 1 word/cycle.
- The last sample is followed by out_valid=0 and underrun=1, both visible in the same cycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with s_valid=1 → s_ready=0, out_a=out_b=0x00, out_valid=0, underrun=0, level=0.
- Single sample: hold=0, push s_data=0x0220 (I1=0, Q1=2, Q2=2, I2=0) → two edges later out_a=0x20, out_b=0x02, out_valid=1 for 1 cycle. Then out_valid=0, outputs 0x00, underrun=1.
- Hold count: hold=3, push 0x0220 then 0x0000 back-to-back → 0x20/0x02 on out_a/out_b for 4 cycles, then 0x00/0x00 with out_valid=1 for 4 cycles, then IDLE with underrun=1.
- Full/backpressure: ena=1, hold=15, push 6 words 0x1111..0x6666 with s_valid held → the first word is popped to the output, then 4 more are accepted into the FIFO. s_ready drops when level=4, and the 6th word waits. Output order is 0x1111, 0x2222, … with no word lost or duplicated.
- Enable freeze: mid-SEND with hold=5, drop ena for 3 cycles → outputs, level and remaining hold frozen and s_ready=0. The sample is visible for 6 enabled cycles in total.
- Underrun clear and reset mid-operation:
  - Assert clr_underrun → underrun=0 next cycle.
  - clr_underrun in the same cycle as a SEND→IDLE transition → underrun=1.
  - rst_n=0 with level=3 in SEND → next cycle level=0, out_valid=0, and no stale word is emitted afterwards.

Source files
------------

// File: rtl/iq_sample_tx.sv
// iq_sample_tx
// Transmit-side sample source for the dual-channel 4-bit I/Q pin interface.
// Complex sample words from an upstream producer are buffered in a small
// circular FIFO. Each word is then driven onto two 8-bit pin buses for
// hold+1 cycles:
//   bus A = {Q1,I1} = s_data[7:0]
//   bus B = {I2,Q2} = s_data[15:8]
//
// Ports:
//   clk, rst_n     rising-edge clock; synchronous active-low reset
//   ena            global enable; 0 freezes every register
//   s_data/s_valid/s_ready
//                  producer handshake (see below)
//   hold           sample hold count; sampled when a word is loaded
//   clr_underrun   clears the sticky underrun flag
//   out_a, out_b   registered pin buses; 0 when no sample is live
//   out_valid      out_a/out_b carry a live sample
//   underrun       sticky; set each time the output stream runs dry
//   level          current FIFO occupancy
//   fsm_state      current output FSM state (0=IDLE, 1=SEND)
//
// Handshake: a word transfers on a rising edge where s_valid & s_ready are
// both 1. s_ready depends only on rst_n, ena and level, never on s_valid.
// The producer holds s_data stable while s_valid=1 and s_ready=0. The word
// popped in a cycle is never the word pushed in that same cycle, so a word
// always spends at least one cycle in the FIFO.
module iq_sample_tx #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [15:0]                  s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [HOLD_W-1:0]            hold,
  input  logic                         clr_underrun,
  output logic [7:0]                   out_a,
  output logic [7:0]                   out_b,
  output logic                         out_valid,
  output logic                         underrun,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [HOLD_W-1:0] hc, hc_next;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [15:0]       mem [DEPTH];

  logic push, pop, load, go_idle;

  // The reset term keeps the producer stalled while reset is held.
  assign s_ready   = rst_n & ena & (level < FULL);
  assign push      = s_valid & s_ready;
  assign fsm_state = state;

  // Next-state logic. A pop always coincides with loading a new sample into
  // the output registers, so pop and load are the same event.
  always_comb begin
    state_next = state;
    hc_next    = hc;
    load       = 1'b0;
    go_idle    = 1'b0;
    if (ena) begin
      case (state)
        IDLE: begin
          if (level != '0) begin
            load       = 1'b1;
            state_next = SEND;
          end
        end
        SEND: begin
          if (hc != '0) begin
            hc_next = hc - HOLD_W'(1);
          end else if (level != '0) begin
            // Back-to-back reload: no gap between samples.
            load = 1'b1;
          end else begin
            go_idle    = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
      if (load) hc_next = hold;
    end
    pop = load;
  end

  // FIFO storage has no reset; its contents are only valid below level.
  always_ff @(posedge clk) begin
    if (rst_n && ena && push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hc        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else if (ena) begin
      state <= state_next;
      hc    <= hc_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (load) begin
        out_a     <= mem[rd_ptr][7:0];
        out_b     <= mem[rd_ptr][15:8];
        out_valid <= 1'b1;
      end else if (go_idle) begin
        out_a     <= '0;
        out_b     <= '0;
        out_valid <= 1'b0;
      end
      // A run-dry event wins over a simultaneous clear.
      if (go_idle)           underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iq_sample_tx.sv
// tb_iq_sample_tx
// Bench for iq_sample_tx. A behavioural model tracks the buffered words, the
// live sample and the number of cycles that sample still has to show. It
// predicts every output at each falling edge. Directed scenarios come first,
// followed by a randomized phase.
module tb_iq_sample_tx;

  localparam int DEPTH  = 4;
  localparam int HOLD_W = 4;
  localparam int LW     = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              ena;
  logic [15:0]       s_data;
  logic              s_valid;
  logic              s_ready;
  logic [HOLD_W-1:0] hold;
  logic              clr_underrun;
  logic [7:0]        out_a;
  logic [7:0]        out_b;
  logic              out_valid;
  logic              underrun;
  logic [LW-1:0]     level;
  logic              fsm_state;

  iq_sample_tx #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .hold(hold),
    .clr_underrun(clr_underrun),
    .out_a(out_a),
    .out_b(out_b),
    .out_valid(out_valid),
    .underrun(underrun),
    .level(level),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [15:0] exp_q[$];  // words accepted and not yet shown
  logic        m_active;  // a sample is live on the buses
  logic [15:0] m_word;    // the live sample
  int          m_left;    // cycles the live sample still has to show
  logic        m_under;
  logic        last_push;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Advance the model over one rising edge, using the inputs driven for it.
  task automatic model_edge();
    logic pu;
    logic went_idle;
    last_push = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_active = 1'b0;
      m_word   = '0;
      m_left   = 0;
      m_under  = 1'b0;
      return;
    end
    if (!ena) return;
    pu        = s_valid && (exp_q.size() < DEPTH);
    went_idle = 1'b0;
    if (!m_active || m_left == 1) begin
      if (exp_q.size() > 0) begin
        m_word   = exp_q.pop_front();
        m_left   = int'(hold) + 1;
        m_active = 1'b1;
      end else if (m_active) begin
        m_active  = 1'b0;
        went_idle = 1'b1;
      end
    end else begin
      m_left--;
    end
    if (went_idle)         m_under = 1'b1;
    else if (clr_underrun) m_under = 1'b0;
    if (pu) exp_q.push_back(s_data);
    last_push = pu;
  endtask

  // ---------------- driver tasks ----------------
  // Each call starts just after a falling edge with the inputs already set.
  // It checks all outputs against the model, crosses one rising edge, and
  // returns at the next falling edge.
  task automatic cycle();
    logic exp_ready;
    #1;
    exp_ready = rst_n && ena && (exp_q.size() < DEPTH);
    check("s_ready",   16'(s_ready),   16'(exp_ready));
    check("out_valid", 16'(out_valid), 16'(m_active));
    check("out_a",     16'(out_a),     m_active ? 16'(m_word[7:0])  : 16'h0);
    check("out_b",     16'(out_b),     m_active ? 16'(m_word[15:8]) : 16'h0);
    check("underrun",  16'(underrun),  16'(m_under));
    check("level",     16'(level),     16'(exp_q.size()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push_wait(input logic [15:0] w, input logic [HOLD_W-1:0] h);
    s_data  = w;
    hold    = h;
    s_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (last_push) break;
    end
    if (!last_push) check("push_timeout", 16'(last_push), 16'h1);
    s_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_q.delete();
    m_active = 1'b0; m_word = '0; m_left = 0; m_under = 1'b0; last_push = 1'b0;
    rst_n = 1'b0; ena = 1'b1; s_valid = 1'b1; s_data = 16'hFFFF;
    hold = '0; clr_underrun = 1'b0;

    // Reset with s_valid asserted; the first edge brings the DUT out of X.
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1; s_valid = 1'b0;
    idle(1);

    // Single sample, hold=0: visible two edges after the push.
    push_wait(16'h0220, 4'd0);
    cycle();
    #1;
    check("single_a",     16'(out_a),     16'h0020);
    check("single_b",     16'(out_b),     16'h0002);
    check("single_valid", 16'(out_valid), 16'h1);
    cycle();
    #1;
    check("single_end_valid", 16'(out_valid), 16'h0);
    check("single_end_under", 16'(underrun),  16'h1);
    idle(2);

    // Hold count of 3 with two back-to-back words.
    push_wait(16'h0220, 4'd3);
    push_wait(16'h0000, 4'd3);
    idle(12);

    // Clear the underrun flag.
    clr_underrun = 1'b1;
    idle(1);
    clr_underrun = 1'b0;
    #1;
    check("clr_under", 16'(underrun), 16'h0);
    idle(1);

    // Backpressure: six words at hold=15; the last one waits for space.
    for (int k = 1; k <= 6; k++) push_wait(16'(k * 16'h1111), 4'd15);
    idle(100);

    // Enable freeze in the middle of a sample.
    push_wait(16'hABCD, 4'd5);
    idle(3);
    ena = 1'b0;
    idle(3);
    ena = 1'b1;
    idle(10);

    // A clear that lands on the run-dry edge loses to the set.
    clr_underrun = 1'b1;
    idle(1);
    clr_underrun = 1'b0;
    push_wait(16'h5A3C, 4'd0);
    cycle();
    clr_underrun = 1'b1;
    cycle();
    clr_underrun = 1'b0;
    #1;
    check("clr_vs_set", 16'(underrun), 16'h1);
    idle(2);

    // Reset while sending with three words buffered.
    for (int k = 0; k < 4; k++) push_wait(16'(16'h1357 + k), 4'd7);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    #1;
    check("rst_level", 16'(level),     16'h0);
    check("rst_valid", 16'(out_valid), 16'h0);
    idle(20);

    // Randomized phase.
    for (int i = 0; i < 800; i++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      ena          = ($urandom_range(0, 7) != 0);
      s_valid      = ($urandom_range(0, 2) != 0);
      s_data       = 16'($urandom());
      hold         = HOLD_W'($urandom_range(0, 3));
      clr_underrun = ($urandom_range(0, 9) == 0);
      cycle();
    end
    rst_n = 1'b1; ena = 1'b1; s_valid = 1'b0; clr_underrun = 1'b0;
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
